mod107_digit_mult_seq: RTL

- Sequential modular multiplier computing (a*b) mod MOD for 7-bit operands; default MOD is 107.
- Each operand is split into three 3-bit digits. The 9 digit-pair partial products are issued one per cycle to a single shared weighted 3x3 digit-multiplier slot.
- Each slot output is a pre-reduced term (a_i*b_j*2^(3(i+j))) mod MOD. The block accumulates these terms mod MOD.
- The block sequences and time-shares the per-weight 3x3 LUT multiplier cores of the mod-107 datapath. It sits between the operand source and the result consumer, with valid/ready on both sides.

---
 rtl/mod107_digit_mult_seq_if.sv | 23 ++
 rtl/mod107_digit_mult_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mod107_digit_mult_seq_if.sv
// Operand/result handshake bundle for the digit-serial modular multiplier.
// master = operand source and result consumer, slave = multiplier.
interface mod107_digit_mult_seq_if #(
    parameter int W = 7
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/mod107_digit_mult_seq.sv
// Sequential (a*b) mod MOD: nine 3x3 digit products, one per cycle,
// through a single weighted, pre-reducing multiplier slot.
module mod107_digit_mult_seq #(
    parameter int MOD = 107
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mod107_digit_mult_seq_if.slave  bus,
    output logic                    busy
);
    localparam int W     = $clog2(MOD);
    localparam int NPAIR = 9;
    localparam int PW    = 13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 2^(3k) mod MOD, folded at elaboration time
    function automatic logic [W-1:0] pow8(input int k);
        int r;
        r = 1;
        for (int n = 0; n < k; n++) r = (r * 8) % MOD;
        return W'(r);
    endfunction

    localparam logic [W-1:0] WT0 = pow8(0);
    localparam logic [W-1:0] WT1 = pow8(1);
    localparam logic [W-1:0] WT2 = pow8(2);
    localparam logic [W-1:0] WT3 = pow8(3);
    localparam logic [W-1:0] WT4 = pow8(4);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, b_q;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] res_q;
    logic [3:0]   step_q;

    logic [1:0]   di, dj;
    logic [2:0]   dk;
    logic [8:0]   a9, b9;
    logic [2:0]   a_dig, b_dig;
    logic [W-1:0] wt;
    logic [PW-1:0] prod;
    logic [W-1:0] term;
    logic [W:0]   sum;

    // step -> (i, j) digit indices, row-major over A digits
    always_comb begin
        di = 2'd0;
        dj = 2'd0;
        case (step_q)
            4'd0: begin di = 2'd0; dj = 2'd0; end
            4'd1: begin di = 2'd0; dj = 2'd1; end
            4'd2: begin di = 2'd0; dj = 2'd2; end
            4'd3: begin di = 2'd1; dj = 2'd0; end
            4'd4: begin di = 2'd1; dj = 2'd1; end
            4'd5: begin di = 2'd1; dj = 2'd2; end
            4'd6: begin di = 2'd2; dj = 2'd0; end
            4'd7: begin di = 2'd2; dj = 2'd1; end
            4'd8: begin di = 2'd2; dj = 2'd2; end
            default: begin di = 2'd0; dj = 2'd0; end
        endcase
    end

    // digit select, weight lookup and the shared reducing multiplier slot
    always_comb begin
        a9 = {2'b00, a_q};
        b9 = {2'b00, b_q};
        case (di)
            2'd0:    a_dig = a9[2:0];
            2'd1:    a_dig = a9[5:3];
            default: a_dig = a9[8:6];
        endcase
        case (dj)
            2'd0:    b_dig = b9[2:0];
            2'd1:    b_dig = b9[5:3];
            default: b_dig = b9[8:6];
        endcase
        dk = {1'b0, di} + {1'b0, dj};
        case (dk)
            3'd0:    wt = WT0;
            3'd1:    wt = WT1;
            3'd2:    wt = WT2;
            3'd3:    wt = WT3;
            default: wt = WT4;
        endcase
        prod = PW'(a_dig) * PW'(b_dig) * PW'(wt);
        term = W'(prod % PW'(MOD));
        sum  = {1'b0, acc_q} + {1'b0, term};
        if (sum >= (W+1)'(MOD)) acc_d = W'(sum - (W+1)'(MOD));
        else                    acc_d = W'(sum);
    end

    // control: accept, nine fixed RUN cycles, hold result until taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_RUN;
            S_RUN:  if (step_q == 4'(NPAIR - 1)) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state, operand capture, accumulation and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.in_a;
                        b_q    <= bus.in_b;
                        acc_q  <= '0;
                        step_q <= '0;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    if (step_q == 4'(NPAIR - 1)) begin
                        res_q  <= acc_d;
                        step_q <= '0;
                    end else begin
                        step_q <= step_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = res_q;
    assign busy           = (state_q != S_IDLE);
endmodule
